// File: rtl/proc_ctrl.sv
// Control FSM for a small bus-based processor: it sequences mv, mvi, add and
// sub over states T0..T3 and drives the register, A, G and IR enables.
module proc_ctrl #(
  parameter int CMD_LENGTH = 9,
  parameter int REG_NUM    = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Run,
  input  logic [CMD_LENGTH-1:0] DIN,
  output logic [REG_NUM-1:0]    Rout,
  output logic                  Gout,
  output logic                  DINout,
  output logic [REG_NUM-1:0]    Rin,
  output logic                  Ain,
  output logic                  Gin,
  output logic                  IRin,
  output logic                  AddSub,
  output logic                  Done
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_e;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  state_e                state_q, state_d;
  logic [CMD_LENGTH-1:0] ir_q, ir_d;
  logic [2:0]            opcode_s, x_s, y_s;
  logic [REG_NUM-1:0]    x_oh_s, y_oh_s;

  // Register indices at or beyond REG_NUM select nothing.
  function automatic logic [REG_NUM-1:0] onehot(input logic [2:0] idx);
    logic [REG_NUM-1:0] oh;
    oh = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (int'(idx) == i) begin
        oh[i] = 1'b1;
      end else begin
        oh[i] = 1'b0;
      end
    end
    return oh;
  endfunction

  assign opcode_s = ir_q[8:6];
  assign x_s      = ir_q[5:3];
  assign y_s      = ir_q[2:0];
  assign x_oh_s   = onehot(x_s);
  assign y_oh_s   = onehot(y_s);
  assign ir_d     = IRin ? DIN : ir_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = T0;
    Rout    = '0;
    Gout    = 1'b0;
    DINout  = 1'b0;
    Rin     = '0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    IRin    = 1'b0;
    AddSub  = 1'b0;
    Done    = 1'b0;
    case (state_q)
      T0: begin
        // IR load is held off while reset is asserted so no output toggles.
        IRin    = Run & ~Reset;
        state_d = Run ? T1 : T0;
      end
      T1: begin
        case (opcode_s)
          OP_MV: begin
            Rout    = y_oh_s;
            Rin     = x_oh_s;
            Done    = 1'b1;
            state_d = T0;
          end
          OP_MVI: begin
            DINout  = 1'b1;
            Rin     = x_oh_s;
            Done    = 1'b1;
            state_d = T0;
          end
          OP_ADD, OP_SUB: begin
            Rout    = x_oh_s;
            Ain     = 1'b1;
            state_d = T2;
          end
          default: begin
            Done    = 1'b1;
            state_d = T0;
          end
        endcase
      end
      T2: begin
        if (opcode_s == OP_ADD || opcode_s == OP_SUB) begin
          Rout    = y_oh_s;
          Gin     = 1'b1;
          AddSub  = (opcode_s == OP_SUB);
          state_d = T3;
        end else begin
          state_d = T0;
        end
      end
      T3: begin
        if (opcode_s == OP_ADD || opcode_s == OP_SUB) begin
          Gout = 1'b1;
          Rin  = x_oh_s;
          Done = 1'b1;
        end else begin
          Done = 1'b0;
        end
        state_d = T0;
      end
      default: begin
        state_d = T0;
      end
    endcase
  end

endmodule
